// File: rtl/spi_memory_pkg.sv
// Opcodes and FSM state encoding shared by the SPI memory controller.
// Defining SPI_WREN_EN adds the WREN/WREN_GAP states used ahead of every write.
package spi_memory_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_WREN  = 8'h06;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_HOLD     = 4'd1,
`ifdef SPI_WREN_EN
      ST_WREN     = 4'd2,
      ST_WREN_GAP = 4'd3,
`endif
      ST_CMD      = 4'd4,
      ST_ADDR_HI  = 4'd5,
      ST_ADDR_LO  = 4'd6,
      ST_DATA     = 4'd7,
      ST_FINISH   = 4'd8
   } state_t;

   function automatic logic [7:0] cmd_opcode(input logic we);
      return we ? OP_WRITE : OP_READ;
   endfunction

endpackage

// File: rtl/spi_shift_byte.sv
// One-byte SPI mode-0 engine: SCLK divider, MSB-first shifter and MISO sampler.
// A start on the cycle done is high chains the next byte with no idle SCLK period.
module spi_shift_byte #(
   parameter int unsigned DIVISOR = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       done,
   output logic [7:0] rx_byte
);

   localparam logic [7:0] DIV_LAST = 8'(DIVISOR - 1);

   logic       active_q, active_d;
   logic       phase_q, phase_d;
   logic [7:0] div_q, div_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] rx_q, rx_d;
   logic       half_end;

   always_comb begin
      active_d = active_q;
      phase_d  = phase_q;
      div_d    = div_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      half_end = active_q && (div_q == DIV_LAST);
      done     = half_end && phase_q && (bit_q == 3'd7);

      if (active_q) begin
         div_d = half_end ? 8'd0 : div_q + 8'd1;
      end
      // Rising SCLK edge samples MISO; falling edge advances MOSI and the bit count.
      if (half_end) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            rx_d = {rx_q[6:0], miso};
         end else begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
         end
      end
      if (done) begin
         active_d = 1'b0;
      end
      if (start) begin
         active_d = 1'b1;
         phase_d  = 1'b0;
         div_d    = 8'd0;
         bit_d    = 3'd0;
         tx_d     = tx_byte;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         div_q    <= 8'd0;
         bit_q    <= 3'd0;
         tx_q     <= 8'h00;
         rx_q     <= 8'h00;
      end else begin
         active_q <= active_d;
         phase_q  <= phase_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
      end
   end

   assign sclk    = active_q & phase_q;
   assign mosi    = active_q & tx_q[7];
   assign rx_byte = rx_q;

endmodule

// File: rtl/spi_memory_controller.sv
// CPU-bus to SPI memory bridge: one 32-bit frame (cmd, addr hi, addr lo, data) per access.
// Define SPI_WREN_EN to send a separate WREN frame before each write (EEPROM parts).
module spi_memory_controller
   import spi_memory_pkg::*;
#(
   parameter int unsigned DIVISOR = 4,
   parameter int unsigned CS_GAP  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   input  logic        bus_enable,
   input  logic        write_enable,
   output logic        busy,
   output logic        ready,
   output logic        spi_cs,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   // FINISH itself is the first CS-high cycle of the gap.
   localparam logic [15:0] GAP_RELOAD = 16'(CS_GAP - 2);
`ifdef SPI_WREN_EN
   localparam logic [15:0] GAP_WREN   = 16'(CS_GAP - 1);
`endif

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [7:0]  dout_q, dout_d;
   logic [15:0] gap_q, gap_d;

   logic        start;
   logic [7:0]  tx_byte;
   logic        done;
   logic [7:0]  rx_byte;
   logic        launch;
   logic        launch_we;
   logic        cs_active;

   spi_shift_byte #(
      .DIVISOR (DIVISOR)
   ) u_shift (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tx_byte (tx_byte),
      .miso    (spi_miso),
      .sclk    (spi_clk),
      .mosi    (spi_mosi),
      .done    (done),
      .rx_byte (rx_byte)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      dout_d    = dout_q;
      gap_d     = gap_q;
      start     = 1'b0;
      tx_byte   = 8'h00;
      launch    = 1'b0;
      launch_we = we_q;

      if (state_q == ST_FINISH) begin
         gap_d = GAP_RELOAD;
      end else if (gap_q != 16'd0) begin
         gap_d = gap_q - 16'd1;
      end

      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (state_q == ST_FINISH) begin
               state_d = ST_IDLE;
            end
            // A request during the CS gap is latched now and launched from HOLD.
            if (bus_enable) begin
               addr_d  = address;
               wdata_d = data_in;
               we_d    = write_enable;
               if ((state_q == ST_IDLE) && (gap_q == 16'd0)) begin
                  launch    = 1'b1;
                  launch_we = write_enable;
               end else begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (gap_q == 16'd0) begin
               launch = 1'b1;
            end
         end
`ifdef SPI_WREN_EN
         ST_WREN: begin
            if (done) begin
               state_d = ST_WREN_GAP;
               gap_d   = GAP_WREN;
            end
         end
         ST_WREN_GAP: begin
            if (gap_q == 16'd0) begin
               state_d = ST_CMD;
               start   = 1'b1;
               tx_byte = OP_WRITE;
            end
         end
`endif
         ST_CMD: begin
            if (done) begin
               state_d = ST_ADDR_HI;
               start   = 1'b1;
               tx_byte = addr_q[15:8];
            end
         end
         ST_ADDR_HI: begin
            if (done) begin
               state_d = ST_ADDR_LO;
               start   = 1'b1;
               tx_byte = addr_q[7:0];
            end
         end
         ST_ADDR_LO: begin
            if (done) begin
               state_d = ST_DATA;
               start   = 1'b1;
               tx_byte = we_q ? wdata_q : 8'h00;
            end
         end
         ST_DATA: begin
            if (done) begin
               state_d = ST_FINISH;
               if (!we_q) begin
                  dout_d = rx_byte;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
`ifdef SPI_WREN_EN
         if (launch_we) begin
            state_d = ST_WREN;
            start   = 1'b1;
            tx_byte = OP_WREN;
         end else
`endif
         begin
            state_d = ST_CMD;
            start   = 1'b1;
            tx_byte = cmd_opcode(launch_we);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         dout_q  <= 8'h00;
         gap_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         dout_q  <= dout_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      cs_active = 1'b0;
      case (state_q)
`ifdef SPI_WREN_EN
         ST_WREN,
`endif
         ST_CMD, ST_ADDR_HI, ST_ADDR_LO, ST_DATA: cs_active = 1'b1;
         default: cs_active = 1'b0;
      endcase
   end

   assign spi_cs   = ~cs_active;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
   assign ready    = (state_q == ST_FINISH);
   assign data_out = dout_q;

endmodule

// File: doc/spi_memory_controller.md
SPI_MEMORY_CONTROLLER -- requirements
Module: spi_memory_controller

Interface
REQ-001 SHALL have parameter DIVISOR, default 4: clk cycles per SCLK half-period (legal 1..255).
REQ-002 SHALL have parameter CS_GAP, default 8: clk cycles CS stays high between back-to-back frames (minimum 2).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 address  in  16  byte address of the external SPI memory.
REQ-006 data_in  in  8  write data.
REQ-007 data_out  out  8  last byte read.
REQ-008 bus_enable  in  1  request strobe; sampled only while idle.
REQ-009 write_enable  in  1  1 = write, 0 = read; sampled with bus_enable.
REQ-010 busy  out  1  transaction in progress; the bus stalls the CPU while it is high.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 spi_cs  out  1  chip select, active low.
REQ-013 spi_clk  out  1  SCLK, mode 0 (idle low).
REQ-014 spi_mosi  out  1  serial data out, MSB first.
REQ-015 spi_miso  in  1  serial data in.

Function
REQ-016 SHALL accept a request when bus_enable=1 and busy=0, latching address, data_in and write_enable, and SHALL raise busy on the next cycle.
REQ-017 SHALL ignore bus_enable while busy=1, with no latching and no queuing.
REQ-018 SHALL sequence states IDLE -> [WREN -> WREN_GAP] -> CMD -> ADDR_HI -> ADDR_LO -> DATA -> FINISH -> IDLE.
REQ-019 CMD byte SHALL be 0x03 for reads and 0x02 for writes, followed by address[15:8] and then address[7:0].
REQ-020 DATA SHALL shift out data_in on writes and shift out 0x00 on reads, capturing spi_miso into the read byte.
REQ-021 Each bit SHALL last 2*DIVISOR cycles: MOSI valid with SCLK low for DIVISOR cycles, then SCLK high for DIVISOR cycles; MISO SHALL be sampled on the clk edge that raises SCLK.
REQ-022 spi_cs SHALL fall on the cycle busy rises and SHALL stay low for exactly 64*DIVISOR cycles per frame (32 bits).
REQ-023 In FINISH, spi_cs SHALL rise, ready SHALL pulse for 1 cycle and busy SHALL fall on that same cycle; on reads data_out SHALL update on the same edge.
REQ-024 Read latency SHALL be 64*DIVISOR+1 cycles from the accepting edge to the ready pulse.
REQ-025 data_out SHALL hold its value until the next completed read; writes SHALL NOT change it.
REQ-026 After FINISH, CS SHALL stay high for at least CS_GAP cycles before the next frame; a request arriving during the gap SHALL be accepted, with CS held high until the gap expires.
REQ-027 The divider counter SHALL wrap from DIVISOR-1 to 0; the bit counter SHALL wrap 7 -> 0 on byte advance.
REQ-028 Address 0xFFFF SHALL be sent unmodified; no auto-increment.

Reset
REQ-029 Asserting reset SHALL immediately force spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, ready=0, data_out=0x00 and state=IDLE.
REQ-030 Reset mid-transaction SHALL abort it with no ready pulse; the first request after release SHALL start a clean frame.

Configuration
REQ-031 With SPI_WREN_EN defined, every write SHALL be preceded by a separate 8-bit frame 0x06 (WREN), then CS high for CS_GAP cycles, adding 16*DIVISOR+CS_GAP cycles of latency (EEPROM targets).
REQ-032 Without SPI_WREN_EN, the WREN/WREN_GAP states SHALL be absent and writes SHALL take the same time as reads (SRAM targets).

Structure
REQ-033 Package spi_memory_pkg SHALL hold the opcode constants (READ 0x03, WRITE 0x02, WREN 0x06) and the state encoding.
REQ-034 Sub-module spi_shift_byte SHALL implement the 8-bit divider, shift and sample engine with start/done handshake; the top SHALL hold only the FSM and latches.

Verification (DIVISOR=2, CS_GAP=4)
REQ-035 Read 0x1234, model returns 0xA5 -> MOSI 03 12 34 00, CS low for 128 cycles, ready at cycle 129, data_out=0xA5.
REQ-036 Write 0x5C to 0xBEEF -> MOSI 02 BE EF 5C; with SPI_WREN_EN, a 06 frame first, then CS high for 4 cycles; data_out unchanged.
REQ-037 bus_enable pulsed at cycle 40 of an active read -> ignored; exactly one ready pulse occurs.
REQ-038 Reset asserted during ADDR_LO -> spi_cs=1, spi_clk=0 and busy=0 within the same cycle, no ready; a following read of 0x0001 completes correctly.
REQ-039 Request held on the ready cycle -> second frame CS falls no earlier than 4 cycles after CS rises; read 0xFFFF sends FF FF.
